paddle_input_ctrl: RTL and testbench
====================================

// Module: paddle_input_ctrl
// PURPOSE
//  Upstream stage of game_controller: turns raw paddle buttons into a clamped
//  paddle position.
//  - Synchronises and debounces btn_up/btn_down.
//  - Moves a 10-bit paddle_loc by STEP once per sample tick while a button is held.
//  - One instance per paddle; outputs feed game_controller's left/right_paddle_loc.
//  - paddle_loc is a registered level, so the slower game clock may sample it at any time.
// PARAMETERS
//  TICK_DIV      262144  board_clk cycles per sample tick (>=2; bench uses 4)
//  DEB_SAMPLES   4       consecutive agreeing ticks needed to change debounced state (>=1)
//  STEP          4       pixels moved per tick
//  PADDLE_MIN    0       smallest legal paddle_loc (top of screen)
//  PADDLE_MAX    400     largest legal paddle_loc (480 minus paddle height 80)
//  PADDLE_INIT   200     paddle_loc after reset; PADDLE_MIN<=INIT<=MAX
// PORTS
//  board_clk    in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  btn_up       in   1   raw, asynchronous, bouncing button; up = decreasing Y
//  btn_down     in   1   raw, asynchronous, bouncing button; down = increasing Y
//  enable       in   1   1 = position may move; 0 = freeze position
//  paddle_loc   out  10  registered paddle top-edge Y coordinate
//  moving_up    out  1   debounced up XOR down, up selected, and enable
//  moving_down  out  1   debounced down XOR up, down selected, and enable
//  at_top       out  1   paddle_loc == PADDLE_MIN (decoded from register)
//  at_bottom    out  1   paddle_loc == PADDLE_MAX (decoded from register)
// BEHAVIOUR
//  Reset (async, any time, including mid-debounce):
//   - paddle_loc=PADDLE_INIT; sync flops, debounced state, debounce counters, tick counter = 0.
//   - All other outputs therefore reset to 0, except at_top/at_bottom, which decode INIT.
//  Synchroniser: 2 flops per button; the second flop is the "sample".
//  Tick:
//   - tick_cnt counts 0..TICK_DIV-1 and wraps.
//   - tick is a 1-cycle pulse when tick_cnt==TICK_DIV-1.
//   - All debounce and position logic advances only on tick cycles.
//  Debounce, per button, on tick:
//   - sample==deb: cnt<=0.
//   - sample!=deb and cnt==DEB_SAMPLES-1: deb<=sample, cnt<=0.
//   - otherwise: cnt<=cnt+1.
//   - A glitch shorter than DEB_SAMPLES ticks never changes deb.
//  Position update, on tick, uses deb values registered before this edge:
//   - enable=0, or up==down: hold.
//   - up only: loc <= (loc-STEP < MIN) ? MIN : loc-STEP.
//   - down only: loc <= (loc+STEP > MAX) ? MAX : loc+STEP.
//   - Compute in 11-bit signed, so no wrap below 0 or above 1023.
//  Latency:
//   - Press held from before tick t1: deb rises at t_DEB_SAMPLES.
//   - First move at the next tick, then one STEP every tick.
//   - Release is symmetric: DEB_SAMPLES ticks to clear deb, one more tick to stop.
//  Boundaries:
//   - At MIN with up held: stays MIN, at_top=1, moving_up stays 1 (reflects intent).
//   - Same at MAX with down held.
//   - Both buttons held: no motion, moving_up=moving_down=0.
//   - enable dropping mid-hold: freezes on the next tick; debounce keeps running.
//   - Re-enable: motion resumes on the first tick, with no extra debounce delay.
// TESTING (TICK_DIV=4, DEB_SAMPLES=4, STEP=4, MIN=0, MAX=400, INIT=200)
//  1 Reset: assert reset mid-count -> paddle_loc=200, moving_*=0, at_top=at_bottom=0, immediately (async).
//  2 Hold btn_up with enable=1 -> deb after 4 ticks; loc 196,192,... one step per tick.
//    Keep holding -> reaches 0 after 50 moves, at_top=1, remains 0.
//  3 Bounce btn_down: toggle every 2 ticks for 20 ticks -> paddle_loc stays 200, moving_down never 1.
//  4 Both buttons held 20 ticks -> paddle_loc constant, moving_up=moving_down=0.
//  5 Hold down from 396 -> 400, then clamps at 400, at_bottom=1.
//    Drop enable mid-hold -> loc frozen; restore -> steps resume next tick.
//  6 Assert reset while deb_up=1 and loc=100 -> loc=200, deb cleared.
//    After release, a fresh 4-tick debounce is needed before motion.

Source files
------------

// File: rtl/paddle_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : paddle_input_ctrl
// Description : Synchronises and debounces paddle buttons, then steps a
//               clamped 10-bit paddle position once per sample tick.
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_input_ctrl #(
  parameter int TICK_DIV    = 262144,
  parameter int DEB_SAMPLES = 4,
  parameter int STEP        = 4,
  parameter int PADDLE_MIN  = 0,
  parameter int PADDLE_MAX  = 400,
  parameter int PADDLE_INIT = 200
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       enable,
  output logic [9:0] paddle_loc,
  output logic       moving_up,
  output logic       moving_down,
  output logic       at_top,
  output logic       at_bottom
);

  localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_DEB_W  = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_SAMPLES - 1);
  localparam logic signed [10:0]  c_STEP_S    = 11'(STEP);
  localparam logic signed [10:0]  c_MIN_S     = 11'(PADDLE_MIN);
  localparam logic signed [10:0]  c_MAX_S     = 11'(PADDLE_MAX);
  localparam logic [9:0]          c_MIN_L     = 10'(PADDLE_MIN);
  localparam logic [9:0]          c_MAX_L     = 10'(PADDLE_MAX);
  localparam logic [9:0]          c_INIT_L    = 10'(PADDLE_INIT);

  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_tick;
  logic [1:0]          w_btn;
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          w_deb;
  logic [9:0]          r_loc;
  logic [9:0]          w_loc_nxt;
  logic signed [10:0]  w_loc_s;
  logic signed [10:0]  w_up_s;
  logic signed [10:0]  w_dn_s;

  // Bit 0 is the up button, bit 1 the down button throughout.
  assign w_btn  = {btn_down, btn_up};
  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      logic               r_deb_bit;
      logic [c_DEB_W-1:0] r_cnt;

      always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
          r_deb_bit <= 1'b0;
          r_cnt     <= '0;
        end else if (w_tick) begin
          if (r_sync2[gi] == r_deb_bit) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_deb_bit <= r_sync2[gi];
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_deb[gi] = r_deb_bit;
    end
  endgenerate

  // Signed 11-bit arithmetic so a step past either end clamps instead of wrapping.
  assign w_loc_s = $signed({1'b0, r_loc});
  assign w_up_s  = w_loc_s - c_STEP_S;
  assign w_dn_s  = w_loc_s + c_STEP_S;

  always_comb begin
    w_loc_nxt = r_loc;
    if (enable && (w_deb[0] != w_deb[1])) begin
      if (w_deb[0]) begin
        w_loc_nxt = (w_up_s < c_MIN_S) ? c_MIN_L : w_up_s[9:0];
      end else begin
        w_loc_nxt = (w_dn_s > c_MAX_S) ? c_MAX_L : w_dn_s[9:0];
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_loc <= c_INIT_L;
    end else if (w_tick) begin
      r_loc <= w_loc_nxt;
    end
  end

  assign paddle_loc  = r_loc;
  assign moving_up   = w_deb[0] & ~w_deb[1] & enable;
  assign moving_down = w_deb[1] & ~w_deb[0] & enable;
  assign at_top      = (r_loc == c_MIN_L);
  assign at_bottom   = (r_loc == c_MAX_L);

endmodule
`default_nettype wire

// File: tb/tb_paddle_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_paddle_input_ctrl
// Description : Self-checking bench for paddle_input_ctrl against a
//               tick-level behavioural model of debounce and clamped motion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_input_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 4;
  localparam int STEP     = 4;
  localparam int PMIN     = 0;
  localparam int PMAX     = 400;
  localparam int PINIT    = 200;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_up    = 1'b0;
  logic       btn_down  = 1'b0;
  logic       enable    = 1'b0;
  logic [9:0] paddle_loc;
  logic       moving_up;
  logic       moving_down;
  logic       at_top;
  logic       at_bottom;

  int checks = 0;
  int errors = 0;

  paddle_input_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_SAMPLES(DEB),
    .STEP       (STEP),
    .PADDLE_MIN (PMIN),
    .PADDLE_MAX (PMAX),
    .PADDLE_INIT(PINIT)
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .enable     (enable),
    .paddle_loc (paddle_loc),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .at_top     (at_top),
    .at_bottom  (at_bottom)
  );

  always #5 board_clk = ~board_clk;

  // Reference model: a button's debounced level becomes s once the last DEB
  // tick samples are all s; the position follows the clamped-step rule.
  int             m_phase;
  logic [1:0]     m_d1, m_d2, m_deb;
  logic [DEB-1:0] m_hist_up, m_hist_dn;
  logic [DEB-1:0] nh_up, nh_dn;
  int             m_loc;

  function automatic int step_loc(int loc, logic up, logic dn, logic en);
    if (!en || up == dn) return loc;
    if (up) return (loc - STEP < PMIN) ? PMIN : loc - STEP;
    return (loc + STEP > PMAX) ? PMAX : loc + STEP;
  endfunction

  assign nh_up = {m_hist_up[DEB-2:0], m_d2[0]};
  assign nh_dn = {m_hist_dn[DEB-2:0], m_d2[1]};

  always @(posedge board_clk or posedge reset) begin
    if (reset) begin
      m_phase   <= 0;
      m_d1      <= '0;
      m_d2      <= '0;
      m_deb     <= '0;
      m_hist_up <= '0;
      m_hist_dn <= '0;
      m_loc     <= PINIT;
    end else begin
      m_d1    <= {btn_down, btn_up};
      m_d2    <= m_d1;
      m_phase <= (m_phase + 1) % TICK_DIV;
      if (m_phase == TICK_DIV - 1) begin
        m_loc     <= step_loc(m_loc, m_deb[0], m_deb[1], enable);
        m_hist_up <= nh_up;
        m_hist_dn <= nh_dn;
        if (nh_up == {DEB{m_d2[0]}}) m_deb[0] <= m_d2[0];
        if (nh_dn == {DEB{m_d2[1]}}) m_deb[1] <= m_d2[1];
      end
    end
  end

  logic [13:0] exp_vec, dut_vec;
  assign exp_vec = {10'(m_loc), m_deb[0] & ~m_deb[1] & enable,
                    m_deb[1] & ~m_deb[0] & enable, m_loc == PMIN, m_loc == PMAX};
  assign dut_vec = {paddle_loc, moving_up, moving_down, at_top, at_bottom};

  task automatic do_reset();
    @(negedge board_clk);
    reset = 1'b1;
    @(negedge board_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge board_clk);
    reset  = 1'b0;
    enable = 1'b1;
    btn_up = 1'b1;
    repeat (10) @(negedge board_clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (paddle_loc !== 10'd200) begin errors++; $display("FAIL reset_loc: got %0d want 200", paddle_loc); end
    checks++; if ({moving_up, moving_down} !== 2'b00) begin errors++; $display("FAIL reset_moving: got %b want 00", {moving_up, moving_down}); end
    checks++; if ({at_top, at_bottom} !== 2'b00) begin errors++; $display("FAIL reset_limits: got %b want 00", {at_top, at_bottom}); end
    @(negedge board_clk);
    reset  = 1'b0;
    btn_up = 1'b0;
    repeat (8) begin
      @(negedge board_clk);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL reset_model: dut=%h model=%h", dut_vec, exp_vec); end
    end
  endtask

  task automatic test_hold_up();
    int first = 0;
    do_reset();
    enable = 1'b1;
    btn_up = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      @(negedge board_clk);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL up_model: cyc %0d dut=%h model=%h", n, dut_vec, exp_vec); end
      if (first == 0 && paddle_loc != 10'd200) begin
        first = n;
        checks++; if (paddle_loc !== 10'd196) begin errors++; $display("FAIL up_first_step: got %0d want 196", paddle_loc); end
      end
    end
    checks++; if (first != 20) begin errors++; $display("FAIL up_latency: got cycle %0d want 20", first); end
    checks++; if (paddle_loc !== 10'd0 || at_top !== 1'b1 || moving_up !== 1'b1) begin
      errors++; $display("FAIL up_clamp: loc=%0d at_top=%b moving_up=%b want 0,1,1", paddle_loc, at_top, moving_up);
    end
    btn_up = 1'b0;
  endtask

  task automatic test_bounce();
    do_reset();
    enable = 1'b1;
    repeat ($urandom_range(0, 3)) @(negedge board_clk);
    repeat (10) begin
      btn_down = ~btn_down;
      repeat (8) begin
        @(negedge board_clk);
        checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL bounce_model: dut=%h model=%h", dut_vec, exp_vec); end
        checks++; if (paddle_loc !== 10'd200 || moving_down !== 1'b0) begin
          errors++; $display("FAIL bounce_hold: loc=%0d moving_down=%b want 200,0", paddle_loc, moving_down);
        end
      end
    end
    btn_down = 1'b0;
  endtask

  task automatic test_both();
    do_reset();
    enable   = 1'b1;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (80) begin
      @(negedge board_clk);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL both_model: dut=%h model=%h", dut_vec, exp_vec); end
      checks++; if (paddle_loc !== 10'd200 || {moving_up, moving_down} !== 2'b00) begin
        errors++; $display("FAIL both_hold: loc=%0d moving=%b want 200,00", paddle_loc, {moving_up, moving_down});
      end
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic test_down_enable();
    int  frozen;
    bit  moved = 1'b0;
    do_reset();
    enable   = 1'b1;
    btn_down = 1'b1;
    repeat (60) begin
      @(negedge board_clk);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL down_model: dut=%h model=%h", dut_vec, exp_vec); end
    end
    frozen = m_loc;
    enable = 1'b0;
    repeat (40) begin
      @(negedge board_clk);
      checks++; if (paddle_loc !== 10'(frozen) || moving_down !== 1'b0) begin
        errors++; $display("FAIL freeze: loc=%0d moving_down=%b want %0d,0", paddle_loc, moving_down, frozen);
      end
    end
    enable = 1'b1;
    for (int n = 0; n < 4 && !moved; n++) begin
      @(negedge board_clk);
      if (paddle_loc != 10'(frozen)) moved = 1'b1;
    end
    checks++; if (!moved || paddle_loc !== 10'(frozen + STEP)) begin
      errors++; $display("FAIL resume: loc=%0d want %0d within one tick", paddle_loc, frozen + STEP);
    end
    repeat (250) begin
      @(negedge board_clk);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL down_clamp_model: dut=%h model=%h", dut_vec, exp_vec); end
    end
    checks++; if (paddle_loc !== 10'd400 || at_bottom !== 1'b1 || moving_down !== 1'b1) begin
      errors++; $display("FAIL down_clamp: loc=%0d at_bottom=%b moving_down=%b want 400,1,1", paddle_loc, at_bottom, moving_down);
    end
    btn_down = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first = 0;
    bit found = 1'b0;
    do_reset();
    enable = 1'b1;
    btn_up = 1'b1;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge board_clk);
      if (m_loc == 100) found = 1'b1;
    end
    checks++; if (!found || paddle_loc !== 10'd100 || moving_up !== 1'b1) begin
      errors++; $display("FAIL reach_100: loc=%0d moving_up=%b want 100,1", paddle_loc, moving_up);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (paddle_loc !== 10'd200 || moving_up !== 1'b0) begin
      errors++; $display("FAIL mid_reset: loc=%0d moving_up=%b want 200,0", paddle_loc, moving_up);
    end
    @(negedge board_clk);
    reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge board_clk);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL mid_model: dut=%h model=%h", dut_vec, exp_vec); end
      if (first == 0 && paddle_loc != 10'd200) first = n;
    end
    checks++; if (first != 20) begin errors++; $display("FAIL redebounce: first move cycle %0d want 20", first); end
    btn_up = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    repeat (800) begin
      @(negedge board_clk);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL random_model: dut=%h model=%h", dut_vec, exp_vec); end
      if ($urandom_range(0, 11) == 0) btn_up   = ~btn_up;
      if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 39) == 0) enable   = ~enable;
    end
  endtask

  initial begin
    test_reset();
    test_hold_up();
    test_bounce();
    test_both();
    test_down_enable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
